// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bundle between mem_wb_stage and memory.
// master: mem_req/mem_we/mem_addr/mem_wdata out; mem_ready/mem_rvalid/mem_rdata in.
interface mem_wb_stage_if #(
    parameter int ADDR_BITS = 16
);
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU writeback in 1 cycle, loads/stores via mem (master
// modport), stall while busy, register-file write port out.
// Ports: clk, rst_n, EX/MEM bundle (*_ex), stall, mem, write_wb,
// writeregsel_wb, writedata, mem_err. Optional macro: MEM_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int ADDR_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_ex,
    input  logic [31:0]           alu_ex,
    input  logic [31:0]           store_data_ex,
    input  logic [4:0]            writeregsel_ex,
    input  logic                  write_ex,
    input  logic                  wb_sel_ex,
    input  logic                  m_write_ex,
    output logic                  stall,
    mem_wb_stage_if.master        mem,
    output logic                  write_wb,
    output logic [4:0]            writeregsel_wb,
    output logic [31:0]           writedata,
    output logic                  mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t     state, state_nx;
    logic [4:0] hold_reg;
    logic       hold_wr;
    logic       is_mem;
    logic       to_hit;

    assign is_mem = wb_sel_ex | m_write_ex;
    assign stall  = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    // A completion (accept in REQ, rvalid in RESP) beats expiry.
    assign to_hit = (cnt >= CW'(TIMEOUT_CYCLES - 1)) &&
                    (((state == REQ) && !mem.mem_ready) ||
                     ((state == RESP) && !mem.mem_rvalid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= to_hit;
            if (state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    // Constant 0 for any legal (non-negative) limit.
    assign mem_err = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (valid_ex && is_mem) state_nx = REQ;
            REQ: begin
                if (mem.mem_ready)
                    state_nx = mem.mem_we ? IDLE : RESP;
                else if (to_hit)
                    state_nx = IDLE;
            end
            RESP: if (mem.mem_rvalid || to_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            hold_reg       <= '0;
            hold_wr        <= 1'b0;
            write_wb       <= 1'b0;
            writeregsel_wb <= '0;
            writedata      <= '0;
        end else begin
            state    <= state_nx;
            write_wb <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_ex && is_mem) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= m_write_ex;
                        mem.mem_addr  <= alu_ex[ADDR_BITS-1:0];
                        mem.mem_wdata <= store_data_ex;
                        hold_reg      <= writeregsel_ex;
                        hold_wr       <= write_ex;
                    end else if (valid_ex) begin
                        write_wb       <= write_ex && (writeregsel_ex != 5'd0);
                        writeregsel_wb <= writeregsel_ex;
                        writedata      <= alu_ex;
                    end
                end
                REQ: begin
                    if (mem.mem_ready || to_hit)
                        mem.mem_req <= 1'b0;
                end
                RESP: begin
                    if (mem.mem_rvalid) begin
                        write_wb       <= hold_wr && (hold_reg != 5'd0);
                        writeregsel_wb <= hold_reg;
                        writedata      <= mem.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed sequences
// and a randomized instruction stream against a spec-level model.
module tb_mem_wb_stage;
`ifdef MEM_TIMEOUT_EN
    localparam int TO   = 8;
    localparam int MAXD = 2;
`else
    localparam int TO   = 64;
    localparam int MAXD = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_ex = 1'b0;
    logic [31:0] alu_ex = '0;
    logic [31:0] store_data_ex = '0;
    logic [4:0]  writeregsel_ex = '0;
    logic        write_ex = 1'b0;
    logic        wb_sel_ex = 1'b0;
    logic        m_write_ex = 1'b0;
    logic        stall;
    logic        write_wb;
    logic [4:0]  writeregsel_wb;
    logic [31:0] writedata;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.ADDR_BITS(16)) mif ();

    mem_wb_stage #(.ADDR_BITS(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_ex       (valid_ex),
        .alu_ex         (alu_ex),
        .store_data_ex  (store_data_ex),
        .writeregsel_ex (writeregsel_ex),
        .write_ex       (write_ex),
        .wb_sel_ex      (wb_sel_ex),
        .m_write_ex     (m_write_ex),
        .stall          (stall),
        .mem            (mif),
        .write_wb       (write_wb),
        .writeregsel_wb (writeregsel_wb),
        .writedata      (writedata),
        .mem_err        (mem_err)
    );

    int pass_n = 0;
    int total_n = 0;
    int wb_seen = 0;
    int wb_exp = 0;

    always @(negedge clk) if (write_wb === 1'b1) wb_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (stall && n < 300) begin
            tick();
            n++;
        end
        if (stall) chk("idle_wait", {31'd0, stall}, 32'd0);
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] rg, input logic wr,
                           input logic wbs, input logic mw);
        valid_ex       = 1'b1;
        alu_ex         = a;
        store_data_ex  = sd;
        writeregsel_ex = rg;
        write_ex       = wr;
        wb_sel_ex      = wbs;
        m_write_ex     = mw;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rg, input logic wr,
                         input logic wbs, input logic mw);
        wait_idle();
        present(a, sd, rg, wr, wbs, mw);
        tick();
        valid_ex = 1'b0;
    endtask

    // Drive the memory side of one access and check the stage's behaviour.
    task automatic serve(input logic [31:0] a, input logic [31:0] sd,
                         input logic st, input logic [4:0] rg,
                         input logic wr, input int rdly, input int rvdly,
                         input logic [31:0] rdata, input logic glitch);
        logic exp_wr;
        exp_wr = wr && (rg != 5'd0);
        for (int i = 0; i < rdly; i++) begin
            chk("req_hold", {31'd0, mif.mem_req}, 32'd1);
            chk("req_addr", {16'd0, mif.mem_addr}, {16'd0, a[15:0]});
            chk("req_we", {31'd0, mif.mem_we}, {31'd0, st});
            chk("stall_req", {31'd0, stall}, 32'd1);
            tick();
        end
        chk("req_on", {31'd0, mif.mem_req}, 32'd1);
        chk("req_addr_acc", {16'd0, mif.mem_addr}, {16'd0, a[15:0]});
        chk("req_we_acc", {31'd0, mif.mem_we}, {31'd0, st});
        if (st) chk("req_wdata", mif.mem_wdata, sd);
        mif.mem_ready = 1'b1;
        if (glitch) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = 32'hBAD0_BAD0;
        end
        tick();
        mif.mem_ready  = 1'b0;
        mif.mem_rvalid = 1'b0;
        chk("req_drop", {31'd0, mif.mem_req}, 32'd0);
        if (st) begin
            chk("st_idle", {31'd0, stall}, 32'd0);
            chk("st_nowb", {31'd0, write_wb}, 32'd0);
        end else begin
            chk("ld_stall", {31'd0, stall}, 32'd1);
            for (int i = 0; i < rvdly - 1; i++) begin
                chk("ld_nowb", {31'd0, write_wb}, 32'd0);
                tick();
            end
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = rdata;
            tick();
            mif.mem_rvalid = 1'b0;
            chk("ld_wb", {31'd0, write_wb}, {31'd0, exp_wr});
            chk("ld_reg", {27'd0, writeregsel_wb}, {27'd0, rg});
            chk("ld_data", writedata, rdata);
            chk("ld_done", {31'd0, stall}, 32'd0);
            if (exp_wr) wb_exp++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [4:0]  rg;
        logic        wr;
        logic        exp_wr;
    } alu_vec_t;

    alu_vec_t vt[6];

    initial begin
        int errs, wb0;
        logic [31:0] a, sd, rd;
        logic [4:0] rg;
        logic wr, wbs, mw;
        int kind;

        vt[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b1};
        vt[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1};
        vt[2] = '{32'h0000_00AB, 5'd0,  1'b1, 1'b0};
        vt[3] = '{32'h0000_0055, 5'd3,  1'b0, 1'b0};
        vt[4] = '{32'h8000_0001, 5'd1,  1'b1, 1'b1};
        vt[5] = '{32'h1357_9BDF, 5'd0,  1'b0, 1'b0};

        mif.mem_ready  = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;

        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mif.mem_addr}, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_wb", {31'd0, write_wb}, 32'd0);
        chk("rst_reg", {27'd0, writeregsel_wb}, 32'd0);
        chk("rst_data", writedata, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU ops from the table, valid held high.
        foreach (vt[i]) begin
            present(vt[i].a, 32'd0, vt[i].rg, vt[i].wr, 1'b0, 1'b0);
            tick();
            chk("alu_wb", {31'd0, write_wb}, {31'd0, vt[i].exp_wr});
            chk("alu_reg", {27'd0, writeregsel_wb}, {27'd0, vt[i].rg});
            chk("alu_data", writedata, vt[i].a);
            chk("alu_stall", {31'd0, stall}, 32'd0);
            if (vt[i].exp_wr) wb_exp++;
        end
        valid_ex = 1'b0;
        tick();
        chk("alu_pulse", {31'd0, write_wb}, 32'd0);
        chk("alu_hold", writedata, vt[5].a);

        // Load: ready after 2 cycles, rvalid 3 cycles after accept.
        issue(32'h0000_0040, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        serve(32'h0000_0040, 32'd0, 1'b0, 5'd7, 1'b1, 2, 3,
              32'hDEAD_BEEF, 1'b0);

        // Store with immediate accept.
        issue(32'h0000_0010, 32'hA5A5_A5A5, 5'd3, 1'b1, 1'b0, 1'b1);
        serve(32'h0000_0010, 32'hA5A5_A5A5, 1'b1, 5'd3, 1'b1, 0, 0,
              32'd0, 1'b0);

        // Load+store flags together behave as a store.
        issue(32'hFFFF_0123, 32'h0BAD_CAFE, 5'd9, 1'b1, 1'b1, 1'b1);
        serve(32'hFFFF_0123, 32'h0BAD_CAFE, 1'b1, 5'd9, 1'b1, 1, 0,
              32'd0, 1'b0);

        // Load with rvalid in the accept cycle; that beat is ignored.
        issue(32'h0000_0200, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0);
        serve(32'h0000_0200, 32'd0, 1'b0, 5'd12, 1'b1, 0, 2,
              32'h1234_5678, 1'b1);

        // ALU op held by upstream while a load is outstanding.
        issue(32'h0000_0080, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        mif.mem_ready = 1'b1;
        tick();
        mif.mem_ready = 1'b0;
        present(32'h0000_0777, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("held_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("held_nowb", {31'd0, write_wb}, 32'd0);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h0000_1111;
        tick();
        mif.mem_rvalid = 1'b0;
        chk("held_ld_wb", {31'd0, write_wb}, 32'd1);
        chk("held_ld_reg", {27'd0, writeregsel_wb}, 32'd9);
        chk("held_ld_data", writedata, 32'h0000_1111);
        tick();
        valid_ex = 1'b0;
        chk("held_alu_wb", {31'd0, write_wb}, 32'd1);
        chk("held_alu_reg", {27'd0, writeregsel_wb}, 32'd4);
        chk("held_alu_data", writedata, 32'h0000_0777);
        wb_exp += 2;

        // Reset while waiting for the load response.
        issue(32'h0000_0300, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        mif.mem_ready = 1'b1;
        tick();
        mif.mem_ready = 1'b0;
        chk("resp_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_req", {31'd0, mif.mem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hCAFE_F00D;
        tick();
        mif.mem_rvalid = 1'b0;
        chk("arst_nowb", {31'd0, write_wb}, 32'd0);
        chk("arst_idle", {31'd0, stall}, 32'd0);
        chk("arst_req2", {31'd0, mif.mem_req}, 32'd0);
        chk("arst_err", {31'd0, mem_err}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Load that is never answered.
        issue(32'h0000_0044, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        errs = 0;
        wb0  = wb_seen;
        for (int i = 0; i < TO + 4; i++) begin
            if (mem_err) errs++;
            tick();
        end
        chk("to_err_once", errs, 32'd1);
        chk("to_idle", {31'd0, stall}, 32'd0);
        chk("to_req", {31'd0, mif.mem_req}, 32'd0);
        chk("to_nowb", wb_seen, wb0);
        issue(32'h0000_0099, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("to_alu_wb", {31'd0, write_wb}, 32'd1);
        chk("to_alu_data", writedata, 32'h0000_0099);
        wb_exp++;
`endif

        // Random instruction stream against the spec-level model.
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            sd   = $urandom;
            rd   = $urandom;
            rg   = 5'($urandom_range(0, 31));
            wr   = 1'($urandom_range(0, 1));
            wbs  = (kind == 2) || ((kind == 3) && ($urandom_range(0, 3) == 0));
            mw   = (kind == 3);
            if (kind < 2) begin
                issue(a, sd, rg, wr, 1'b0, 1'b0);
                chk("r_alu_wb", {31'd0, write_wb},
                    {31'd0, wr && (rg != 5'd0)});
                chk("r_alu_reg", {27'd0, writeregsel_wb}, {27'd0, rg});
                chk("r_alu_data", writedata, a);
                if (wr && (rg != 5'd0)) wb_exp++;
            end else begin
                issue(a, sd, rg, wr, wbs, mw);
                serve(a, sd, mw, rg, wr, $urandom_range(0, MAXD),
                      $urandom_range(1, MAXD), rd,
                      1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        chk("wb_count", wb_seen, wb_exp);
        chk("end_err", {31'd0, mem_err}, 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Back half of the pipeline: accepts EX/MEM results, performs data-memory load/store through a req/ready/rvalid handshake, and drives the register-file write port (write_wb, writeregsel_wb, writedata) consumed by decode.
- Multi-cycle memory accesses stall upstream stages.
- ALU results complete in one cycle.

Parameters:
- ADDR_BITS, 16, data-memory address width; mem_addr = alu_ex[ADDR_BITS-1:0]
- TIMEOUT_CYCLES, 64, response timeout limit; used only with MEM_TIMEOUT_EN

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_ex  input  1  EX/MEM holds a valid instruction
- alu_ex  input  32  ALU result / memory address
- store_data_ex  input  32  store data
- writeregsel_ex  input  5  destination register
- write_ex  input  1  instruction writes register file
- wb_sel_ex  input  1  1 = load (writeback from memory), 0 = ALU
- m_write_ex  input  1  store
- stall  output  1  upstream must hold EX/MEM contents
- mem_req  output  1  memory request
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  ADDR_BITS  request address
- mem_wdata  output  32  store data
- mem_ready  input  1  request accepted this cycle
- mem_rvalid  input  1  load data valid
- mem_rdata  input  32  load data
- write_wb  output  1  register-file write enable
- writeregsel_wb  output  5  register-file write address
- writedata  output  32  register-file write data
- mem_err  output  1  timeout pulse (MEM_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata are all 0.
  - write_wb, writeregsel_wb, writedata, mem_err are all 0.
  - Reset mid-access abandons the access; no writeback occurs.
  - Any later mem_rvalid is ignored until a new load reaches RESP.
- FSM states: IDLE, REQ, RESP.
- stall = (state != IDLE), combinational.
- Inputs are sampled only at a posedge with state==IDLE and valid_ex=1.
- IDLE, non-memory instruction (wb_sel_ex=0, m_write_ex=0):
  - Next cycle: write_wb = write_ex & (writeregsel_ex != 0).
  - writeregsel_wb = writeregsel_ex; writedata = alu_ex.
  - State stays IDLE; latency is 1 cycle.
- IDLE, load (wb_sel_ex=1) or store (m_write_ex=1):
  - Latch mem_addr, mem_wdata = store_data_ex, and writeregsel_ex/write_ex into hold registers.
  - mem_we = m_write_ex; next cycle mem_req=1; go to REQ.
  - If both wb_sel_ex and m_write_ex are set, treat as a store.
- REQ:
  - mem_req and all request fields stay stable until a posedge with mem_ready=1.
  - On that edge mem_req drops to 0.
  - Store: go to IDLE; write_wb stays 0.
  - Load: go to RESP.
- RESP:
  - Wait for mem_rvalid; mem_rvalid is sampled only in RESP.
  - On a posedge with mem_rvalid=1: next cycle write_wb = held write & (held reg != 0), writeregsel_wb = held reg, writedata = mem_rdata; go to IDLE.
  - mem_rvalid in the same cycle as mem_ready (state REQ) is ignored; earliest legal response is one cycle after accept.
- write_wb:
  - Single-cycle pulse per completion; otherwise 0.
  - writeregsel_wb and writedata hold their last values between pulses.
- Register x0 is never written: write_wb is forced 0 when the destination is 0.
- Back-to-back ALU instructions with stall=0: one writeback per cycle.
- An instruction presented while stall=1 is held by upstream and accepted on the first posedge in IDLE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When the counter reaches TIMEOUT_CYCLES without completion: drop mem_req, pulse mem_err for 1 cycle, return to IDLE, no writeback.
  - A mem_rvalid arriving on the expiry edge wins: normal writeback, no mem_err.
- MEM_TIMEOUT_EN undefined:
  - No counter; the FSM waits indefinitely.
  - mem_err is constant 0.

Test Plan:
- Reset, then ALU op (valid_ex=1, alu_ex=0x0000_1234, writeregsel_ex=5, write_ex=1) -> next cycle write_wb=1, writeregsel_wb=5, writedata=0x1234, stall=0.
- Load alu_ex=0x0040, reg 7, mem_ready after 2 cycles, mem_rvalid 3 cycles later with rdata=0xDEADBEEF -> mem_req held stable with mem_addr=0x0040, mem_we=0; stall=1 throughout; write_wb=1 with reg 7, data 0xDEADBEEF one cycle after rvalid.
- Store alu_ex=0x0010, store_data_ex=0xA5A5A5A5, mem_ready immediate -> single-cycle mem_req with mem_we=1 and mem_wdata=0xA5A5A5A5; write_wb stays 0; IDLE after accept.
- ALU op to reg 0 with write_ex=1 -> write_wb stays 0.
- rst_n asserted low while in RESP, then mem_rvalid=1 after release -> no write_wb; state IDLE; mem_req=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load never answered -> mem_err pulses once, stall releases, no write_wb; a following ALU op completes normally.
